pe_driver: RTL and testbench
============================

PE_DRIVER -- requirements
Module: pe_driver

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the operand, bias and pe_acc width.
REQ-002 Parameter PE_OUT_WIDTH, default 8, SHALL set the pe_acc_out and res_data width.
REQ-003 Parameter MAX_LEN, default 16, SHALL set the maximum beats per vector.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-006 op_valid  in  1 / op_ready  out  1  SHALL form the operand-beat handshake; a beat transfers when both are high.
REQ-007 op_a, op_b  in  DATA_WIDTH each  SHALL carry the operand pair.
REQ-008 op_last  in  1  SHALL mark the final beat of a vector.
REQ-009 bias  in  DATA_WIDTH  SHALL be the initial accumulator, sampled on the first beat only.
REQ-010 pe_inp, pe_out, pe_acc  out  DATA_WIDTH  SHALL drive the PE inp_in, out_in and acc_in ports.
REQ-011 pe_acc_out  in  PE_OUT_WIDTH  SHALL receive the PE registered acc_out.
REQ-012 res_valid  out  1 / res_ready  in  1  SHALL form the result handshake.
REQ-013 res_data  out  PE_OUT_WIDTH  SHALL carry the dot-product result.
REQ-014 res_count  out  $clog2(MAX_LEN+1)  SHALL carry the number of beats consumed.
REQ-015 res_trunc  out  1  SHALL flag that the vector was cut at MAX_LEN.

Function
REQ-016 The FSM SHALL have four states: IDLE, ACCUM, FLUSH, HOLD.
REQ-017 op_ready SHALL be 1 in IDLE and ACCUM, and 0 in FLUSH, HOLD and during rst.
REQ-018 On a beat transfer, pe_inp/pe_out SHALL equal op_a/op_b combinationally in the same cycle.
REQ-019 pe_acc SHALL equal bias on the first beat and pe_acc_out[DATA_WIDTH-1:0] (zero-extended if narrower) on later beats and bubbles.
REQ-020 With no transfer (bubble or non-ACCUM state), pe_inp and pe_out SHALL be 0, so the PE holds its value; pe_acc SHALL be 0 in IDLE.
REQ-021 IDLE->ACCUM SHALL occur on a first-beat transfer without op_last; IDLE->FLUSH SHALL occur on a first beat with op_last.
REQ-022 ACCUM->FLUSH SHALL occur on a transfer with op_last, or on the beat that makes the count equal MAX_LEN.
REQ-023 A MAX_LEN cut without op_last SHALL set res_trunc=1; later beats start a new vector.
REQ-024 FLUSH SHALL last one cycle, loading res_data<=pe_acc_out and res_count, then go to HOLD.
REQ-025 res_valid SHALL be high exactly in HOLD, i.e. from 2 cycles after the last-beat transfer.
REQ-026 res_data/res_count/res_trunc SHALL stay stable while res_valid=1 and res_ready=0.
REQ-027 HOLD->IDLE SHALL occur in the cycle res_ready=1; back-to-back throughput SHALL be N+2 cycles per N-beat vector.
REQ-028 Arithmetic SHALL wrap modulo 2^PE_OUT_WIDTH, consistent with the PE; no saturation.

Reset
REQ-029 rst SHALL force state IDLE, the beat counter to 0, res_valid=0, res_data=0, res_count=0 and res_trunc=0 on the next edge.
REQ-030 A reset mid-vector or during HOLD SHALL discard the partial or pending result with no res_valid pulse.
REQ-031 During rst, pe_inp, pe_out and pe_acc SHALL be 0.

Structure
REQ-032 Package pe_pkg SHALL hold the state enum, the DATA_WIDTH/PE_OUT_WIDTH/MAX_LEN defaults and the count-width function.
REQ-033 The block SHALL be a single module with no sub-module; the bench SHALL instantiate the existing PE as its partner.

Verification
REQ-034 Stimulus: (2,3),(4,5),(1,1,last), bias 0, res_ready=1. Required: res_data=27, res_count=3, res_valid 2 cycles after the last beat.
REQ-035 Stimulus: single beat (16,16,last), bias 0. Required: res_data=0 (wrap); then (15,17,last), bias 1, gives 0.
REQ-036 Stimulus: (2,3), 3 bubble cycles, (1,4,last), bias 5. Required: res_data=15, res_count=2.
REQ-037 Stimulus: res_ready=0 for 5 cycles after res_valid. Required: op_ready=0 and res_data stable throughout; one transfer when res_ready rises.
REQ-038 Stimulus: 16 beats of (1,1) without last, MAX_LEN=16. Required: res_data=16 mod 256, res_count=16, res_trunc=1.
REQ-039 Stimulus: rst after 2 beats, then (3,3,last), bias 0. Required: no earlier res_valid, then res_data=9, res_count=1.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and defaults for the PE driver: FSM state encoding,
// default widths/lengths and the beat-count width helper.
package pe_pkg;

  localparam int DATA_WIDTH_DEF   = 8;
  localparam int PE_OUT_WIDTH_DEF = 8;
  localparam int MAX_LEN_DEF      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Width needed to hold a beat count from 0 up to and including max_len.
  function automatic int cnt_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/pe_driver.sv
// Streams operand pairs into an external MAC processing element, seeds its
// accumulator with a bias on the first beat, feeds the registered result
// back on later beats, and presents the finished dot product on a
// valid/ready result port.
//
// Handshakes: a beat moves when op_valid && op_ready in the same cycle; a
// result moves when res_valid && res_ready in the same cycle. Once raised,
// res_valid and res_data/res_count/res_trunc hold until the result moves.
module pe_driver
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int PE_OUT_WIDTH = PE_OUT_WIDTH_DEF,
  parameter int MAX_LEN      = MAX_LEN_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [DATA_WIDTH-1:0]      op_a,
  input  logic [DATA_WIDTH-1:0]      op_b,
  input  logic                       op_last,
  input  logic [DATA_WIDTH-1:0]      bias,
  output logic [DATA_WIDTH-1:0]      pe_inp,
  output logic [DATA_WIDTH-1:0]      pe_out,
  output logic [DATA_WIDTH-1:0]      pe_acc,
  input  logic [PE_OUT_WIDTH-1:0]    pe_acc_out,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [PE_OUT_WIDTH-1:0]    res_data,
  output logic [cnt_w(MAX_LEN)-1:0]  res_count,
  output logic                       res_trunc,
  output logic [1:0]                 state_dbg
);

  localparam int CW = cnt_w(MAX_LEN);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          cut;
  logic          xfer;
  logic          at_max;

  assign state_dbg = state;
  assign op_ready  = !rst && (state == IDLE || state == ACCUM);
  assign xfer      = op_valid && op_ready;
  assign cnt_next  = cnt + 1'b1;
  assign at_max    = (cnt_next == CW'(MAX_LEN));

  // PE drive: operands only on a transfer so the PE holds during bubbles;
  // accumulator input is the bias on the first beat, else the fed-back result.
  always_comb begin
    pe_inp = '0;
    pe_out = '0;
    pe_acc = '0;
    if (!rst) begin
      if (xfer) begin
        pe_inp = op_a;
        pe_out = op_b;
      end
      if (state == IDLE) begin
        pe_acc = xfer ? bias : '0;
      end else begin
        pe_acc = DATA_WIDTH'(pe_acc_out);
      end
    end
  end

  // Vector sequencing: count beats, close the vector on op_last or MAX_LEN,
  // wait one cycle for the PE register, then hold the result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cut       <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_count <= '0;
      res_trunc <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (xfer) begin
            cnt <= cnt_next;
            if (op_last || at_max) begin
              state <= FLUSH;
              cut   <= !op_last;
            end else begin
              state <= ACCUM;
            end
          end
        end
        FLUSH: begin
          res_data  <= pe_acc_out;
          res_count <= cnt;
          res_trunc <= cut;
          res_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cnt       <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_driver.sv
// Bench for pe_driver with a behavioural MAC PE partner, a dot-product
// reference model with an expected-result queue, directed vectors with
// literal expectations and a randomized phase.
`timescale 1ns/1ps
module tb_pe_driver;

  localparam int DW = 8;
  localparam int OW = 8;
  localparam int ML = 16;
  localparam int CW = $clog2(ML + 1);
  localparam int EW = OW + CW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [DW-1:0] op_a = '0;
  logic [DW-1:0] op_b = '0;
  logic          op_last = 1'b0;
  logic [DW-1:0] bias = '0;
  logic [DW-1:0] pe_inp, pe_out, pe_acc;
  logic [OW-1:0] pe_acc_out;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [OW-1:0] res_data;
  logic [CW-1:0] res_count;
  logic          res_trunc;
  logic [1:0]    state_dbg;

  pe_driver #(.DATA_WIDTH(DW), .PE_OUT_WIDTH(OW), .MAX_LEN(ML)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_last(op_last), .bias(bias),
    .pe_inp(pe_inp), .pe_out(pe_out), .pe_acc(pe_acc),
    .pe_acc_out(pe_acc_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_count(res_count), .res_trunc(res_trunc),
    .state_dbg(state_dbg)
  );

  // Partner PE: registered multiply-accumulate, wrapping at OW bits.
  always @(posedge clk) begin
    if (rst) pe_acc_out <= '0;
    else     pe_acc_out <= OW'(pe_acc + pe_inp * pe_out);
  end

  // ---------------- check bookkeeping ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  bit            in_vec = 0;
  int            m_sum = 0;
  int            m_cnt = 0;
  int            cyc = 0;
  int            last_push_cyc = 0;
  bit            prev_valid = 0;
  bit            hold_chk = 0;
  logic [OW-1:0] h_data;
  logic [CW-1:0] h_cnt;
  logic          h_trunc;

  always @(negedge clk) begin
    logic          xfer;
    logic [EW-1:0] e;
    logic [OW-1:0] ed;
    cyc++;
    if (rst) begin
      chk("rst_op_ready", op_ready, 0);
      chk("rst_pe_zero", {pe_inp, pe_out, pe_acc}, 0);
      exp_q.delete();
      in_vec     = 0;
      prev_valid = 0;
      hold_chk   = 0;
    end else begin
      chk("op_ready", op_ready, (exp_q.size() == 0));
      xfer = op_valid && op_ready;
      if (xfer) begin
        chk("pe_inp", pe_inp, op_a);
        chk("pe_out", pe_out, op_b);
        if (!in_vec) chk("pe_acc_bias", pe_acc, bias);
        else         chk("pe_acc_fb", pe_acc, DW'(pe_acc_out));
      end else begin
        chk("pe_ops_bubble", {pe_inp, pe_out}, 0);
        if (in_vec)                   chk("pe_acc_hold", pe_acc, DW'(pe_acc_out));
        else if (exp_q.size() == 0)   chk("pe_acc_idle", pe_acc, 0);
      end
      if (hold_chk) begin
        chk("res_stay_valid", res_valid, 1);
        chk("res_stable", {res_data, res_count, res_trunc}, {h_data, h_cnt, h_trunc});
      end
      if (res_valid && !prev_valid) chk("res_latency", cyc - last_push_cyc, 2);
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          chk("res_spurious", res_valid, 0);
        end else begin
          e = exp_q[0];
          chk("res_model", {res_data, res_count, res_trunc}, e);
          if (res_ready) void'(exp_q.pop_front());
        end
      end
      hold_chk   = res_valid && !res_ready;
      h_data     = res_data;
      h_cnt      = res_count;
      h_trunc    = res_trunc;
      prev_valid = res_valid;
      if (xfer) begin
        if (!in_vec) begin
          m_sum  = int'(bias);
          m_cnt  = 0;
          in_vec = 1;
        end
        m_sum = m_sum + int'(op_a) * int'(op_b);
        m_cnt++;
        if (op_last || m_cnt == ML) begin
          ed = m_sum[OW-1:0];
          exp_q.push_back({ed, CW'(m_cnt), !op_last});
          in_vec        = 0;
          last_push_cyc = cyc;
        end
      end
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic send_beat(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic last, input logic [DW-1:0] bs);
    int n = 0;
    op_valid = 1'b1; op_a = a; op_b = b; op_last = last; bias = bs;
    @(negedge clk);
    while (!op_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!op_ready) chk("beat_timeout", op_ready, 1);
    @(posedge clk); #1;
    op_valid = 1'b0; op_a = '0; op_b = '0; op_last = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Leaves the bench at the negedge where res_valid is first seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    @(negedge clk);
    while (!res_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (!res_valid) chk("res_timeout", res_valid, 1);
  endtask

  task automatic wait_result(input string name, input logic [OW-1:0] d,
                             input logic [CW-1:0] c, input logic t, input int exp_lat);
    int lat;
    wait_valid(lat);
    chk({name, "_data"}, res_data, d);
    chk({name, "_count"}, res_count, c);
    chk({name, "_trunc"}, res_trunc, t);
    if (exp_lat >= 0) chk({name, "_lat"}, lat, exp_lat);
    @(posedge clk); #1;
  endtask

  // Background random res_ready during the random phase.
  bit rand_ready = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) res_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int len;
    int n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_res_data", res_data, 0);
    chk("reset_res_count", res_count, 0);
    chk("reset_res_trunc", res_trunc, 0);
    chk("reset_op_ready", op_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_state", state_dbg, 0);
    chk("idle_op_ready", op_ready, 1);
    @(posedge clk); #1;

    // Three-beat dot product.
    send_beat(8'd2, 8'd3, 1'b0, 8'd0);
    send_beat(8'd4, 8'd5, 1'b0, 8'd0);
    send_beat(8'd1, 8'd1, 1'b1, 8'd0);
    wait_result("dot3", 8'd27, 5'd3, 1'b0, 1);

    // Wrap on single-beat vectors.
    send_beat(8'd16, 8'd16, 1'b1, 8'd0);
    wait_result("wrap1", 8'd0, 5'd1, 1'b0, 1);
    send_beat(8'd15, 8'd17, 1'b1, 8'd1);
    wait_result("wrap2", 8'd0, 5'd1, 1'b0, 1);

    // Bubbles between beats with a bias.
    send_beat(8'd2, 8'd3, 1'b0, 8'd5);
    idle_cycles(3);
    send_beat(8'd1, 8'd4, 1'b1, 8'd9);
    wait_result("bubble", 8'd15, 5'd2, 1'b0, 1);

    // Backpressure on the result port.
    res_ready = 1'b0;
    send_beat(8'd2, 8'd2, 1'b1, 8'd1);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_op_ready", op_ready, 0);
      chk("bp_data", res_data, 8'd5);
      chk("bp_valid", res_valid, 1);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_take_valid", res_valid, 1);
    @(negedge clk);
    chk("bp_one_transfer", res_valid, 0);
    @(posedge clk); #1;

    // MAX_LEN cut without op_last.
    for (int i = 0; i < ML; i++) send_beat(8'd1, 8'd1, 1'b0, 8'd0);
    wait_result("trunc", 8'd16, 5'd16, 1'b1, 1);

    // Reset mid-vector discards the partial sum.
    send_beat(8'd7, 8'd7, 1'b0, 8'd3);
    send_beat(8'd5, 8'd5, 1'b0, 8'd0);
    rst = 1'b1;
    idle_cycles(1);
    rst = 1'b0;
    send_beat(8'd3, 8'd3, 1'b1, 8'd0);
    wait_result("rst_mid", 8'd9, 5'd1, 1'b0, 1);

    // Reset during HOLD discards the pending result.
    res_ready = 1'b0;
    send_beat(8'd5, 8'd5, 1'b1, 8'd0);
    wait_valid(lat);
    @(posedge clk); #1;
    rst = 1'b1;
    idle_cycles(1);
    rst = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_hold_no_valid", res_valid, 0);
    end
    @(posedge clk); #1;

    // Randomized vectors, lengths straddling MAX_LEN, random backpressure.
    rand_ready = 1;
    for (int v = 0; v < 25; v++) begin
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
        send_beat(8'($urandom), 8'($urandom), (i == len - 1), 8'($urandom));
      end
    end
    @(posedge clk); #1;
    rand_ready = 0;
    res_ready  = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);

    idle_cycles(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
